// File: rtl/q2_sequencer_if.sv
// Q2 sequencer port bundle: front panel, opcode/dbus inputs and datapath strobes.
// Latency: wires only, no storage.
// Backpressure: none; the datapath accepts every strobe in the clock it is driven.
interface q2_sequencer_if;
  // Front panel and datapath status into the sequencer
  logic       run;
  logic       step;
  logic       dep_sw;
  logic       incp_db;
  logic [3:0] opcode;
  logic       dbus7;
  logic       x0;
  logic       alu_cout;

  // Bus read enables
  logic       rdp;
  logic       rdx;
  logic       rda;
  logic       rdm;

  // Write and increment strobes
  logic       wro;
  logic       wra;
  logic       wrx;
  logic       wrp;
  logic       wrm;
  logic       incp;

  // X register input selects
  logic       xhin_shift;
  logic       xhin_p;
  logic       xhin_zero;
  logic       xhin_dbus;
  logic       xlin_shift;
  logic       xlin_dbus;

  // Serial carry, flag and activity
  logic       cin;
  logic       f;
  logic       busy;

  modport master (
    input  run, step, dep_sw, incp_db, opcode, dbus7, x0, alu_cout,
    output rdp, rdx, rda, rdm,
    output wro, wra, wrx, wrp, wrm, incp,
    output xhin_shift, xhin_p, xhin_zero, xhin_dbus, xlin_shift, xlin_dbus,
    output cin, f, busy
  );

  modport slave (
    output run, step, dep_sw, incp_db, opcode, dbus7, x0, alu_cout,
    input  rdp, rdx, rda, rdm,
    input  wro, wra, wrx, wrp, wrm, incp,
    input  xhin_shift, xhin_p, xhin_zero, xhin_dbus, xlin_shift, xlin_dbus,
    input  cin, f, busy
  );
endinterface

// File: rtl/q2_sequencer.sv
// Q2 bit-serial CPU control sequencer: state/phase register, strobe decode, carry/flag flops, panel handling.
// Latency: ALU class 6+2*WIDTH clocks, st/jump/nop 4 clocks, +2 with DEREF; panel pulses 1 clock.
// Backpressure: none; panel edges outside IDLE, and lower-priority edges in the same clock, are dropped.
module q2_sequencer #(
  parameter int WIDTH = 8
) (
  input  logic           clk,
  input  logic           rstn,
  q2_sequencer_if.master bus
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_DEREF,
    S_LOAD,
    S_EXEC,
    S_ALU
  } state_t;

  state_t        state;
  logic          phase_b;     // 0 = phase A (enables only), 1 = phase B (strobes)
  logic [CW-1:0] bit_cnt;
  logic [2:0]    opc;         // latched {op5,op4,op3}; op2 only steers FETCH
  logic          cin_q;
  logic          f_q;
  logic          dep_pulse;
  logic          incp_pulse;

  // [0],[1] synchroniser, [2] edge-detect history
  logic [2:0]    step_sync;
  logic [2:0]    dep_sync;
  logic [2:0]    incp_sync;
  logic          step_edge;
  logic          dep_edge;
  logic          incp_edge;

  logic          is_alu;
  logic          is_st;
  logic          is_jmp;
  logic          jmp_taken;

  assign step_edge = step_sync[1] & ~step_sync[2];
  assign dep_edge  = dep_sync[1]  & ~dep_sync[2];
  assign incp_edge = incp_sync[1] & ~incp_sync[2];

  assign is_alu    = ~opc[2];
  assign is_st     = (opc == 3'b101);
  assign is_jmp    = (opc[2:1] == 2'b11);
  // op3 makes the jump conditional on a clear flag
  assign jmp_taken = is_jmp & (~opc[0] | ~f_q);

  // Bring the asynchronous panel switches into the clock domain and keep one cycle of history
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      step_sync <= '0;
      dep_sync  <= '0;
      incp_sync <= '0;
    end else begin
      step_sync <= {step_sync[1:0], bus.step};
      dep_sync  <= {dep_sync[1:0],  bus.dep_sw};
      incp_sync <= {incp_sync[1:0], bus.incp_db};
    end
  end

  // Instruction sequencer: state/phase walk, opcode latch, bit counter, carry and flag
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state      <= S_IDLE;
      phase_b    <= 1'b0;
      bit_cnt    <= '0;
      opc        <= '0;
      cin_q      <= 1'b0;
      f_q        <= 1'b0;
      dep_pulse  <= 1'b0;
      incp_pulse <= 1'b0;
    end else begin
      dep_pulse  <= 1'b0;
      incp_pulse <= 1'b0;
      if (state == S_IDLE) begin
        // One panel action per clock: deposit beats increment beats step/run
        if (dep_edge) begin
          dep_pulse <= 1'b1;
        end else if (incp_edge) begin
          incp_pulse <= 1'b1;
        end else if (step_edge || bus.run) begin
          state   <= S_FETCH;
          phase_b <= 1'b0;
        end
      end else if (!phase_b) begin
        phase_b <= 1'b1;
      end else begin
        phase_b <= 1'b0;
        unique case (state)
          S_FETCH: begin
            opc <= bus.opcode[3:1];
            if (bus.opcode[0])      state <= S_DEREF;
            else if (!bus.opcode[3]) state <= S_LOAD;
            else                    state <= S_EXEC;
          end
          S_DEREF: begin
            state <= is_alu ? S_LOAD : S_EXEC;
          end
          S_LOAD: begin
            state <= S_EXEC;
          end
          S_EXEC: begin
            if (is_alu) begin
              state <= S_ALU;
              // Carry seed: ld/nor pass through with 1, add starts clean, shr shifts in x0
              unique case (opc[1:0])
                2'b00:   cin_q <= 1'b1;
                2'b01:   cin_q <= 1'b1;
                2'b10:   cin_q <= 1'b0;
                default: cin_q <= bus.x0;
              endcase
            end else begin
              state <= bus.run ? S_FETCH : S_IDLE;
            end
          end
          S_ALU: begin
            cin_q <= bus.alu_cout;
            if (bit_cnt == LAST_BIT) begin
              f_q     <= bus.alu_cout;
              bit_cnt <= '0;
              state   <= bus.run ? S_FETCH : S_IDLE;
            end else begin
              bit_cnt <= bit_cnt + CW'(1);
            end
          end
          default: begin
            state <= S_IDLE;
          end
        endcase
      end
    end
  end

  // Decode enables, selects and strobes from the registered state and phase
  always_comb begin
    bus.rdp        = 1'b0;
    bus.rda        = 1'b0;
    bus.rdm        = 1'b0;
    bus.wro        = 1'b0;
    bus.wra        = 1'b0;
    bus.wrx        = 1'b0;
    bus.wrp        = 1'b0;
    bus.wrm        = dep_pulse;
    bus.incp       = incp_pulse;
    bus.xhin_shift = 1'b0;
    bus.xhin_p     = 1'b0;
    bus.xhin_zero  = 1'b0;
    bus.xhin_dbus  = 1'b0;
    bus.xlin_shift = 1'b0;
    bus.xlin_dbus  = 1'b0;
    unique case (state)
      S_FETCH: begin
        bus.rdp       = 1'b1;
        bus.rdm       = 1'b1;
        // dbus7 picks whether X high gets P or zero during fetch
        bus.xhin_p    = ~bus.dbus7;
        bus.xhin_zero = bus.dbus7;
        bus.wro       = phase_b;
        bus.wrx       = phase_b;
        bus.incp      = phase_b;
      end
      S_DEREF, S_LOAD: begin
        bus.rdm       = 1'b1;
        bus.xhin_dbus = 1'b1;
        bus.xlin_dbus = 1'b1;
        bus.wrx       = phase_b;
      end
      S_EXEC: begin
        bus.rda = 1'b1;
        bus.wrm = phase_b & is_st;
        bus.wrp = phase_b & jmp_taken;
      end
      S_ALU: begin
        bus.rdp        = 1'b1;
        bus.rdm        = 1'b1;
        bus.xhin_shift = 1'b1;
        bus.xlin_shift = 1'b1;
        bus.wra        = phase_b;
        bus.wrx        = phase_b;
      end
      default: begin
      end
    endcase
  end

  assign bus.rdx  = ~bus.rdp;
  assign bus.cin  = cin_q;
  assign bus.f    = f_q;
  assign bus.busy = (state != S_IDLE);

endmodule

// File: tb/tb_q2_sequencer.sv
// Self-checking bench for q2_sequencer: random instruction stream against a slot-level reference model.
// Latency: checks every clock of every instruction, including back-to-back FETCH with run held high.
// Backpressure: panel inputs exercised in IDLE; deposit/step collision and async reset mid-ALU covered.
module tb_q2_sequencer;

  localparam int W = 8;

  // Slot kinds of the reference schedule
  localparam int K_IDLE  = 0;
  localparam int K_FETCH = 1;
  localparam int K_DEREF = 2;
  localparam int K_LOAD  = 3;
  localparam int K_EXEC  = 4;
  localparam int K_ALU   = 5;

  logic clk;
  logic rstn;
  int   checks;
  int   errors;
  logic f_m;
  logic cin_m;

  q2_sequencer_if sif ();

  q2_sequencer #(.WIDTH(W)) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (sif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%h want=%h", tag, act, exp);
    end
  endtask

  // {rdp,rdx,rda,rdm,wro,wra,wrx,wrp,wrm,incp,xhs,xhp,xhz,xhd,xls,xld,cin,f,busy}
  function automatic logic [18:0] observed();
    return {sif.rdp, sif.rdx, sif.rda, sif.rdm, sif.wro, sif.wra, sif.wrx, sif.wrp,
            sif.wrm, sif.incp, sif.xhin_shift, sif.xhin_p, sif.xhin_zero, sif.xhin_dbus,
            sif.xlin_shift, sif.xlin_dbus, sif.cin, sif.f, sif.busy};
  endfunction

  // Expected outputs for one clock, written straight from the decode table
  function automatic logic [18:0] expected(input int k, input bit phb, input logic d7,
                                           input logic [3:0] op, input logic fm, input logic cm);
    logic bsy, rdp_e, rda_e, rdm_e, wro_e, wra_e, wrx_e, wrp_e, wrm_e, xs, xp, xz, xd;
    bsy   = (k != K_IDLE);
    rdp_e = (k == K_FETCH) || (k == K_ALU);
    rda_e = (k == K_EXEC);
    rdm_e = bsy && (k != K_EXEC);
    wro_e = phb && (k == K_FETCH);
    wra_e = phb && (k == K_ALU);
    wrx_e = phb && (k == K_FETCH || k == K_DEREF || k == K_LOAD || k == K_ALU);
    wrm_e = phb && (k == K_EXEC) && (op[3:1] == 3'b101);
    wrp_e = phb && (k == K_EXEC) && (op[3:2] == 2'b11) && (!op[1] || !fm);
    xs    = (k == K_ALU);
    xp    = (k == K_FETCH) && !d7;
    xz    = (k == K_FETCH) && d7;
    xd    = (k == K_DEREF) || (k == K_LOAD);
    return {rdp_e, !rdp_e, rda_e, rdm_e, wro_e, wra_e, wrx_e, wrp_e, wrm_e, wro_e,
            xs, xp, xz, xd, xs, xd, cm, fm, bsy};
  endfunction

  // Runs one instruction from its FETCH A clock; abort_at >= 0 pulls reset in that slot
  task automatic run_instr(input logic [3:0] op, input int abort_at, input bit last);
    int   sch[$];
    int   bit_i;
    int   wra_cnt;
    int   k;
    bit   phb;
    sch = {};
    sch.push_back(K_FETCH); sch.push_back(K_FETCH);
    if (op[0]) begin sch.push_back(K_DEREF); sch.push_back(K_DEREF); end
    if (!op[3]) begin sch.push_back(K_LOAD); sch.push_back(K_LOAD); end
    sch.push_back(K_EXEC); sch.push_back(K_EXEC);
    if (!op[3]) for (int i = 0; i < 2 * W; i++) sch.push_back(K_ALU);
    sif.opcode = op;
    bit_i   = 0;
    wra_cnt = 0;
    for (int s = 0; s < sch.size(); s++) begin
      @(negedge clk);
      sif.dbus7    = 1'($urandom);
      sif.x0       = 1'($urandom);
      sif.alu_cout = 1'($urandom);
      sif.dep_sw   = last ? 1'b0 : 1'($urandom);
      if (last && s == 0) sif.run = 1'b0;
      if (s == abort_at) begin
        #1;
        rstn = 1'b0;
        f_m   = 1'b0;
        cin_m = 1'b0;
        #1;
        chk("reset_mid_alu", 32'(observed()),
            32'(expected(K_IDLE, 1'b0, sif.dbus7, op, f_m, cin_m)));
        return;
      end
      #1;
      k   = sch[s];
      phb = (s % 2) == 1;
      chk($sformatf("op%b_slot%0d", op, s), 32'(observed()),
          32'(expected(k, phb, sif.dbus7, op, f_m, cin_m)));
      if (sif.wra) wra_cnt++;
      if (phb && k == K_EXEC && !op[3]) begin
        case (op[2:1])
          2'b00, 2'b01: cin_m = 1'b1;
          2'b10:        cin_m = 1'b0;
          default:      cin_m = sif.x0;
        endcase
      end
      if (phb && k == K_ALU) begin
        cin_m = sif.alu_cout;
        if (bit_i == W - 1) f_m = sif.alu_cout;
        bit_i++;
      end
    end
    chk($sformatf("wra_count_op%b", op), 32'(wra_cnt), op[3] ? 32'd0 : 32'(W));
  endtask

  task automatic idle_check(input string tag);
    @(negedge clk);
    #1;
    chk(tag, 32'(observed()), 32'(expected(K_IDLE, 1'b0, sif.dbus7, sif.opcode, f_m, cin_m)));
  endtask

  // Bounded wait for the sequencer to leave IDLE; returns on the edge that entered FETCH
  task automatic wait_busy(input string tag, input int limit);
    bit found;
    found = 1'b0;
    for (int i = 0; i < limit && !found; i++) begin
      @(posedge clk);
      #1;
      if (sif.busy) found = 1'b1;
    end
    chk(tag, 32'(found), 32'd1);
  endtask

  // Drives panel inputs for a few clocks in IDLE and tallies what comes out
  task automatic panel_burst(input logic dep, input logic inc, input logic stp,
                             output int wrm_cnt, output int incp_cnt, output int busy_cnt);
    wrm_cnt = 0; incp_cnt = 0; busy_cnt = 0;
    @(negedge clk);
    sif.dep_sw = dep; sif.incp_db = inc; sif.step = stp;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      #1;
      if (sif.wrm)  wrm_cnt++;
      if (sif.incp) incp_cnt++;
      if (sif.busy) busy_cnt++;
    end
    sif.dep_sw = 1'b0; sif.incp_db = 1'b0; sif.step = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  initial begin
    logic [3:0] fixed_ops [10];
    int wc, ic, bc;
    checks = 0;
    errors = 0;
    f_m    = 1'b0;
    cin_m  = 1'b0;
    fixed_ops = '{4'b0000, 4'b0100, 4'b1110, 4'b1100, 4'b1010,
                  4'b1000, 4'b0011, 4'b1111, 4'b0110, 4'b1011};

    rstn = 1'b0;
    sif.run = 1'b1; sif.step = 1'b0; sif.dep_sw = 1'b0; sif.incp_db = 1'b0;
    sif.opcode = 4'b0000; sif.dbus7 = 1'b0; sif.x0 = 1'b0; sif.alu_cout = 1'b0;

    // Reset held with run high
    repeat (3) @(negedge clk);
    #1;
    chk("reset_state", 32'(observed()), 32'(expected(K_IDLE, 1'b0, 1'b0, 4'b0000, 1'b0, 1'b0)));
    rstn = 1'b1;

    // Continuous run: directed opcodes first, then random ones, back to back
    foreach (fixed_ops[i]) run_instr(fixed_ops[i], -1, 1'b0);
    for (int i = 0; i < 20; i++) run_instr(4'($urandom), -1, 1'b0);
    // run drops during the final instruction: it completes, then IDLE
    run_instr(4'($urandom), -1, 1'b1);
    idle_check("idle_after_run_drop");
    idle_check("idle_hold");

    // Single step of a deref store with run low
    sif.opcode = 4'b1011;
    @(negedge clk);
    sif.step = 1'b1;
    wait_busy("step_starts_fetch", 8);
    sif.step = 1'b0;
    run_instr(4'b1011, -1, 1'b1);
    idle_check("idle_after_step");

    // Deposit and step edges together: one wrm, no fetch
    panel_burst(1'b1, 1'b0, 1'b1, wc, ic, bc);
    chk("dep_step_wrm", 32'(wc), 32'd1);
    chk("dep_step_busy", 32'(bc), 32'd0);
    chk("dep_step_incp", 32'(ic), 32'd0);

    // Increment alone: one incp, no fetch
    panel_burst(1'b0, 1'b1, 1'b0, wc, ic, bc);
    chk("incp_only_incp", 32'(ic), 32'd1);
    chk("incp_only_wrm", 32'(wc), 32'd0);
    chk("incp_only_busy", 32'(bc), 32'd0);

    // Async reset at ALU bit 3 phase A of an add
    @(negedge clk);
    sif.run = 1'b1;
    wait_busy("run_starts_fetch", 4);
    run_instr(4'b0100, 12, 1'b0);
    @(negedge clk);
    #1;
    chk("reset_still_held", 32'(observed()), 32'(expected(K_IDLE, 1'b0, 1'b0, 4'b0000, 1'b0, 1'b0)));
    sif.run = 1'b0;
    rstn = 1'b1;
    idle_check("idle_after_reset_release");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1);
  end

endmodule

// File: doc/q2_sequencer.md
# q2_sequencer

Parametrised control sequencer for the Q2 bit-serial CPU. It owns the instruction state register, the two-phase write-strobe timing, the serial carry and flag flops, and front-panel run/step/deposit handling. It drives the same datapath strobe set as the combinational control decoder, with the ALU bit count set by `WIDTH`. It sits between the front panel, the opcode/dbus source and the Q2 register/ALU datapath.

## Interface
- `WIDTH`, default 8: datapath word width and number of ALU bit-cycles. Must be ≥2.
- `clk` in 1: system clock. All state changes on the rising edge.
- `rstn` in 1: reset. Asynchronous, active-low.
- `run` in 1: level. When high, the sequencer executes instructions continuously.
- `step`, `dep_sw`, `incp_db` in 1: asynchronous front-panel inputs. Each is synchronised internally with 2 flops, then rising-edge detected.
- `opcode` in 4: {op5,op4,op3,op2}. Sampled on the FETCH phase-B edge.
- `dbus7` in 1: data bus bit 7. Used in FETCH only.
- `x0`, `alu_cout` in 1: X register LSB and serial ALU carry-out.
- `rdp`, `rdx`, `rda`, `rdm` out 1: bus read enables.
- `wro`, `wra`, `wrx`, `wrp`, `wrm` out 1: write strobes.
- `incp` out 1: P increment strobe.
- `xhin_shift`, `xhin_p`, `xhin_zero`, `xhin_dbus`, `xlin_shift`, `xlin_dbus` out 1: X input selects.
- `cin` out 1: serial carry flop to the ALU.
- `f` out 1: flag register.
- `busy` out 1: high whenever the state is not IDLE.

## Operation
- **States:** IDLE, FETCH, DEREF, LOAD, EXEC, ALU.
  - Every non-IDLE state has phase A (enables/selects only) then phase B (enables/selects plus strobes). Each phase lasts 1 clock.
  - ALU repeats A/B `WIDTH` times. A bit counter of clog2(WIDTH) bits counts 0..WIDTH-1.
- **Opcode classes:**
  - op5=0: ALU class. op4:op3 selects 00 ld, 01 nor, 10 add, 11 shr.
  - 101: st.
  - 11x: jump. op3=1 makes it conditional on f=0.
  - 100: nop.
- **Sequences** (DEREF is inserted after FETCH when op2=1):
  - ALU class: FETCH→[DEREF]→LOAD→EXEC→ALU→next.
  - st, jump, nop: FETCH→[DEREF]→EXEC→next.
- **next:** FETCH if `run`=1, else IDLE.
- **Leaving IDLE.** The following are accepted only in IDLE, at most one per clock, priority dep_sw > incp_db > step. Lower-priority edges arriving in the same clock are dropped.
  - dep_sw edge: `wrm` for 1 clock.
  - incp_db edge: `incp` for 1 clock.
  - step edge, or `run`=1: go to FETCH A.
- **Output decode.** Outputs are decoded from registered state/phase. The only combinational input paths are `dbus7` and `f`. Phase-B-only strobes are marked "B".
  - FETCH: `rdp`.
    - `xhin_p` = ~dbus7; `xhin_zero` = dbus7.
    - B: `wro`, `wrx`, `incp`.
  - DEREF, LOAD: `rdm`, `xhin_dbus`, `xlin_dbus`.
    - B: `wrx`.
  - EXEC: `rda`.
    - B: `wrm` if st.
    - B: `wrp` if jump and (op3=0 or f=0).
  - ALU: `rdp`, `rdm`, `xhin_shift`, `xlin_shift`.
    - B: `wra`, `wrx`.
  - `rdx` = ~`rdp` in every state.
  - `rdm` = ~EXEC in non-IDLE states; 0 in IDLE.
- **Carry.**
  - EXEC B of the ALU class sets `cin`: ld=1, nor=1, add=0, shr=`x0`.
  - Each ALU B sets `cin` <= `alu_cout`.
  - The last ALU B also sets `f` <= `alu_cout`. `f` is otherwise held.

## Timing
- **Reset.**
  - State IDLE, phase A, bit counter 0, `cin`=0, `f`=0, latched opcode 0.
  - Synchronisers and edge detectors are cleared.
  - All strobes, enables and `busy` are 0. `rdx`=1.
- **Reset asserted mid-instruction.** Immediate return to the reset values. Any strobe in progress is cut. No partial `f` update.
- **Instruction latency:**
  - ALU class: 6+2·WIDTH clocks; 22 clocks at WIDTH=8.
  - st/jump/nop: 4 clocks.
  - DEREF adds 2 clocks.
- **Step.** The step edge is seen after the 2-flop synchroniser plus 1 edge flop. FETCH A follows on the next clock.
- **run.**
  - `run` falling mid-instruction: the instruction completes, then the sequencer goes to IDLE.
  - `run`=1 at the final phase B: FETCH A follows with no IDLE clock.
- **Strobe width.** Each strobe is high for exactly 1 clock, never in two consecutive clocks. Exception: ALU `wra`/`wrx` recur every 2nd clock.
- **Bit counter.** Wraps to 0 on leaving ALU.

## Test plan
- **Reset:** rstn low with `run`=1 → all strobes 0, `busy`=0, `rdx`=1, `f`=0. rstn release with `run`=1 → FETCH A, `rdp`=1, 1 clock later.
- **ld direct, WIDTH=8:** opcode=0000, `run`=1 → 22 clocks FETCH-to-FETCH. 8 `wra` pulses. `cin`=1 at the first ALU bit.
- **add:** opcode=0100, `alu_cout`=1 on bit 7 only → `f`=1 after the last ALU B. `cin`=0 at bit 0.
- **Conditional jump:** opcode=1110 with `f`=1 → no `wrp`. Same with `f`=0 → `wrp` at EXEC B. Both take 4 clocks.
- **Deref st, panel idle:** opcode=1011, `run`=0, one step edge → FETCH, DEREF, EXEC (`wrm`), IDLE; 6 clocks. Then dep_sw and step edges in the same clock → one `wrm`, no FETCH.
- **Reset mid-ALU at bit 3:** → outputs drop asynchronously. `f` is unchanged from its pre-instruction value only if reset is not asserted; otherwise `f`=0.
